// File: rtl/rooth_uart_loader.sv
// rooth_uart_loader
// Receives a framed program image on the debug UART (8N1, LSB first) and
// writes it into instruction memory one 32-bit little-endian word at a time,
// holding the core in reset while a load is in progress.
//
// Frame: 0xA5, LEN_LO, LEN_HI, N*4 data bytes, [CSUM]
//   CSUM = sum mod 256 of LEN_LO, LEN_HI and every data byte.
//
// Optional feature macro: ROOTH_LOADER_CSUM_EN
//   defined   : the frame ends with a CSUM byte that is verified.
//   undefined : no CSUM byte; success is signalled the cycle after the last
//               word write (or right after LEN_HI when N == 0), and
//               err_flags[0] is tied to 0.
//
// Ports
//   clk            system clock
//   rst_n          async active-low reset
//   uart_debug_pin serial RX line, idle high
//   err_clr        one-cycle pulse clearing err_flags
//   mem_we         instruction memory write strobe (one cycle per word)
//   mem_addr       word address of the write
//   mem_wdata      write data
//   core_rst_n     active-low reset request to the core (0 while loading)
//   load_busy      high from the sync byte until frame end or abort
//   load_done      one-cycle pulse on a successful load
//   err_flags      sticky {timeout, overflow, checksum}
`timescale 1ns/1ps
module rooth_uart_loader #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_WIDTH   = 12,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_debug_pin,
    input  logic                  err_clr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic [2:0]            err_flags
);

    localparam int CYC_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW          = $clog2(CYC_PER_BIT + 1);
    localparam int TW          = $clog2(TIMEOUT_BITS + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CYC_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CYC_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_BITS);
    localparam logic [16:0]   DEPTH     = 17'(2 ** ADDR_WIDTH);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;

    rx_st_e        rx_st_q;
    logic [2:0]    sync_q;      // [0],[1] synchronizer, [2] previous sample for edge detect
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_sh_q;
    logic [7:0]    rx_byte_q;
    logic          rx_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st_q   <= RX_IDLE;
            sync_q    <= 3'b111;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_byte_q <= '0;
            rx_vld_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], uart_debug_pin};
            rx_vld_q <= 1'b0;
            case (rx_st_q)
                RX_IDLE: begin
                    if (sync_q[2] && !sync_q[1]) begin
                        rx_st_q  <= RX_START;
                        rx_cnt_q <= '0;
                    end
                end
                RX_START: begin
                    // Re-check the start bit half a bit in; a high line here
                    // means the edge was a glitch.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_st_q  <= sync_q[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {sync_q[1], rx_sh_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                        rx_bit_q <= rx_bit_q + 1'b1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: begin // RX_STOP
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= RX_IDLE;
                        // Framing error: drop the byte without any side effect.
                        if (sync_q[1]) begin
                            rx_byte_q <= rx_sh_q;
                            rx_vld_q  <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA
`ifdef ROOTH_LOADER_CSUM_EN
        , ST_CSUM
`endif
    } st_e;

    st_e                   st_q;
    logic [15:0]           len_q;
    logic [16:0]           idx_q;
    logic [1:0]            bcnt_q;
    logic [23:0]           word_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  core_rst_q;
    logic                  busy_q;
    logic                  done_q;
    logic [2:0]            err_q;
    logic [2:0]            err_set_d;
    logic                  fin_pend;
    logic                  tmo;
    logic                  abort;
    logic                  last_word;
    logic [CW-1:0]         tdiv_q;
    logic [TW-1:0]         tbits_q;

`ifdef ROOTH_LOADER_CSUM_EN
    logic [7:0] sum_q;
    assign fin_pend = 1'b0;
`else
    // Success is reported one cycle after the last write strobe.
    logic fin_q;
    assign fin_pend = fin_q;
`endif

    // Inter-byte timeout, counted in bit-times; restarts on every byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdiv_q  <= '0;
            tbits_q <= '0;
        end else if (st_q == ST_IDLE || rx_vld_q) begin
            tdiv_q  <= '0;
            tbits_q <= '0;
        end else if (tdiv_q == BIT_LAST) begin
            tdiv_q  <= '0;
            if (!tmo) tbits_q <= tbits_q + 1'b1;
        end else begin
            tdiv_q <= tdiv_q + 1'b1;
        end
    end

    assign tmo       = (tbits_q == TMO_LIM);
    // A byte landing in the timeout cycle still counts as on time.
    assign abort     = (st_q != ST_IDLE) && tmo && !rx_vld_q && !fin_pend;
    assign last_word = ((idx_q + 17'd1) == {1'b0, len_q});

    always_comb begin
        err_set_d    = '0;
        err_set_d[2] = abort;
        err_set_d[1] = (st_q == ST_DATA) && rx_vld_q && !fin_pend &&
                       (bcnt_q == 2'd3) && (idx_q >= DEPTH);
`ifdef ROOTH_LOADER_CSUM_EN
        err_set_d[0] = (st_q == ST_CSUM) && rx_vld_q && (rx_byte_q != sum_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
`ifdef ROOTH_LOADER_CSUM_EN
            sum_q       <= '0;
`else
            fin_q       <= 1'b0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            // A flag being set wins over a same-cycle clear.
            err_q    <= (err_q & ~{3{err_clr}}) | err_set_d;
`ifndef ROOTH_LOADER_CSUM_EN
            fin_q    <= 1'b0;
`endif
            if (fin_pend) begin
                done_q     <= 1'b1;
                core_rst_q <= 1'b1;
                busy_q     <= 1'b0;
                st_q       <= ST_IDLE;
            end else if (abort) begin
                busy_q <= 1'b0;
                st_q   <= ST_IDLE;
            end else if (rx_vld_q) begin
                case (st_q)
                    ST_IDLE: begin
                        if (rx_byte_q == SYNC_BYTE) begin
                            st_q       <= ST_LEN_LO;
                            busy_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                            idx_q      <= '0;
                            bcnt_q     <= '0;
`ifdef ROOTH_LOADER_CSUM_EN
                            sum_q      <= '0;
`endif
                        end
                    end
                    ST_LEN_LO: begin
                        len_q[7:0] <= rx_byte_q;
`ifdef ROOTH_LOADER_CSUM_EN
                        sum_q      <= sum_q + rx_byte_q;
`endif
                        st_q       <= ST_LEN_HI;
                    end
                    ST_LEN_HI: begin
                        len_q[15:8] <= rx_byte_q;
`ifdef ROOTH_LOADER_CSUM_EN
                        sum_q       <= sum_q + rx_byte_q;
`endif
                        if ({rx_byte_q, len_q[7:0]} != 16'd0) begin
                            st_q <= ST_DATA;
                        end else begin
`ifdef ROOTH_LOADER_CSUM_EN
                            st_q <= ST_CSUM;
`else
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b1;
                            busy_q     <= 1'b0;
                            st_q       <= ST_IDLE;
`endif
                        end
                    end
                    ST_DATA: begin
`ifdef ROOTH_LOADER_CSUM_EN
                        sum_q  <= sum_q + rx_byte_q;
`endif
                        bcnt_q <= bcnt_q + 1'b1;
                        word_q <= {rx_byte_q, word_q[23:8]};
                        if (bcnt_q == 2'd3) begin
                            // Words past the end of memory are received but not written.
                            if (idx_q < DEPTH) begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= idx_q[ADDR_WIDTH-1:0];
                                mem_wdata_q <= {rx_byte_q, word_q};
                            end
                            idx_q <= idx_q + 17'd1;
                            if (last_word) begin
`ifdef ROOTH_LOADER_CSUM_EN
                                st_q  <= ST_CSUM;
`else
                                fin_q <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef ROOTH_LOADER_CSUM_EN
                    ST_CSUM: begin
                        busy_q <= 1'b0;
                        st_q   <= ST_IDLE;
                        if (rx_byte_q == sum_q) begin
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b1;
                        end
                    end
`endif
                    default: st_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_rst_n = core_rst_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign err_flags  = err_q;

endmodule

// File: tb/tb_rooth_uart_loader.sv
`timescale 1ns/1ps
module tb_rooth_uart_loader;
    localparam int CLKF = 1000000;
    localparam int BAUD = 100000;
    localparam int CPB  = 10;

    logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
    logic uart0 = 1'b1, uart1 = 1'b1;

    logic        we0, busy0, crst0, done0;
    logic [11:0] addr0;
    logic [31:0] data0;
    logic [2:0]  err0;
    logic        we1, busy1, crst1, done1;
    logic [0:0]  addr1;
    logic [31:0] data1;
    logic [2:0]  err1;

    always #5 clk = ~clk;

    rooth_uart_loader #(.CLK_FREQ(CLKF), .BAUD(BAUD), .ADDR_WIDTH(12), .TIMEOUT_BITS(64)) u0 (
        .clk(clk), .rst_n(rst_n), .uart_debug_pin(uart0), .err_clr(err_clr),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(data0), .core_rst_n(crst0),
        .load_busy(busy0), .load_done(done0), .err_flags(err0));

    rooth_uart_loader #(.CLK_FREQ(CLKF), .BAUD(BAUD), .ADDR_WIDTH(1), .TIMEOUT_BITS(64)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_debug_pin(uart1), .err_clr(err_clr),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(data1), .core_rst_n(crst1),
        .load_busy(busy1), .load_done(done1), .err_flags(err1));

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: expected write stream per DUT, and a running count of done pulses.
    int          exp_a0[$], exp_a1[$];
    logic [31:0] exp_d0[$], exp_d1[$];
    int          done0_cnt = 0, done1_cnt = 0;
    logic        pd0 = 1'b0, pd1 = 1'b0;
    logic [31:0] fw [0:7];

    always @(negedge clk) begin : mon0
        int          a;
        logic [31:0] d;
        if (rst_n) begin
            if (we0) begin
                if (exp_a0.size() == 0) check("wr0_unexpected", {31'd0, we0}, 32'd0);
                else begin
                    a = exp_a0.pop_front();
                    d = exp_d0.pop_front();
                    check("wr0_addr", {20'd0, addr0}, a);
                    check("wr0_data", data0, d);
                    check("wr0_busy_hold", {30'd0, busy0, crst0}, 32'd2);
                end
            end
            if (done0) begin
                done0_cnt++;
                check("done0_single", {31'd0, pd0}, 32'd0);
                check("done0_release", {30'd0, crst0, busy0}, 32'd2);
            end
        end
        pd0 <= done0;
    end

    always @(negedge clk) begin : mon1
        int          a;
        logic [31:0] d;
        if (rst_n) begin
            if (we1) begin
                if (exp_a1.size() == 0) check("wr1_unexpected", {31'd0, we1}, 32'd0);
                else begin
                    a = exp_a1.pop_front();
                    d = exp_d1.pop_front();
                    check("wr1_addr", {31'd0, addr1}, a);
                    check("wr1_data", data1, d);
                end
            end
            if (done1) begin
                done1_cnt++;
                check("done1_single", {31'd0, pd1}, 32'd0);
            end
        end
        pd1 <= done1;
    end

    task automatic set_line(input int dut, input logic v);
        if (dut == 0) uart0 = v; else uart1 = v;
    endtask

    task automatic send_byte(input int dut, input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_line(dut, fr[i]);
            repeat (CPB) @(negedge clk);
        end
    endtask

    function automatic logic [7:0] frame_sum(input int n);
        logic [7:0] s;
        s = 8'(n) + 8'(n >> 8);
        for (int w = 0; w < n; w++)
            for (int k = 0; k < 4; k++) s = s + fw[w][8*k +: 8];
        return s;
    endfunction

    // Sends a full frame built from fw[0..n-1]; queues the writes that must
    // appear (only words below the memory depth).
    task automatic send_frame(input int dut, input int n, input int depth,
                              input bit bad_csum, input bit glitch);
        logic [7:0] s;
        s = frame_sum(n);
        send_byte(dut, 8'hA5);
        send_byte(dut, 8'(n));
        send_byte(dut, 8'(n >> 8));
        if (glitch) begin
            set_line(dut, 1'b0);
            repeat (3) @(negedge clk);
            set_line(dut, 1'b1);
            repeat (30) @(negedge clk);
        end
        for (int w = 0; w < n; w++) begin
            if (w < depth) begin
                if (dut == 0) begin exp_a0.push_back(w); exp_d0.push_back(fw[w]); end
                else          begin exp_a1.push_back(w); exp_d1.push_back(fw[w]); end
            end
            for (int k = 0; k < 4; k++) send_byte(dut, fw[w][8*k +: 8]);
        end
`ifdef ROOTH_LOADER_CSUM_EN
        send_byte(dut, bad_csum ? s + 8'd1 : s);
`endif
    endtask

    int snap;

    task automatic expect_end(input string nm, input int dut, input int ndone,
                              input logic crst, input logic [2:0] err);
        repeat (40) @(negedge clk);
        if (dut == 0) begin
            check({nm, "_done"}, done0_cnt - snap, ndone);
            check({nm, "_core_rst_n"}, {31'd0, crst0}, {31'd0, crst});
            check({nm, "_busy"}, {31'd0, busy0}, 32'd0);
            check({nm, "_err"}, {29'd0, err0}, {29'd0, err});
            check({nm, "_wr_left"}, exp_a0.size(), 32'd0);
        end else begin
            check({nm, "_done"}, done1_cnt - snap, ndone);
            check({nm, "_core_rst_n"}, {31'd0, crst1}, {31'd0, crst});
            check({nm, "_busy"}, {31'd0, busy1}, 32'd0);
            check({nm, "_err"}, {29'd0, err1}, {29'd0, err});
            check({nm, "_wr_left"}, exp_a1.size(), 32'd0);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_we"},    {31'd0, we0},   32'd0);
        check({nm, "_addr"},  {20'd0, addr0}, 32'd0);
        check({nm, "_wdata"}, data0,          32'd0);
        check({nm, "_crst"},  {31'd0, crst0}, 32'd1);
        check({nm, "_busy"},  {31'd0, busy0}, 32'd0);
        check({nm, "_done"},  {31'd0, done0}, 32'd0);
        check({nm, "_err"},   {29'd0, err0},  32'd0);
    endtask

    initial begin : stim
        int cyc;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Pin the model's checksum against hand-computed values.
        fw[0] = 32'h0000_0013; fw[1] = 32'h0010_0093;
        check("model_csum_main", {24'd0, frame_sum(2)}, 32'h0000_00B8);
        fw[0] = 32'hDEAD_BEEF;
        check("model_csum_glitch", {24'd0, frame_sum(1)}, 32'h0000_0039);

        // Glitch between header and data must not inject a byte.
        snap = done0_cnt;
        send_frame(0, 1, 4096, 1'b0, 1'b1);
        expect_end("glitch", 0, 1, 1'b1, 3'b000);

        // Main frame.
        fw[0] = 32'h0000_0013; fw[1] = 32'h0010_0093;
        snap = done0_cnt;
        send_frame(0, 2, 4096, 1'b0, 1'b0);
        expect_end("main", 0, 1, 1'b1, 3'b000);

`ifdef ROOTH_LOADER_CSUM_EN
        // Bad checksum: data written, core held, checksum flag sticky.
        snap = done0_cnt;
        send_frame(0, 2, 4096, 1'b1, 1'b0);
        expect_end("badcsum", 0, 0, 1'b0, 3'b001);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("badcsum_clr", {29'd0, err0}, 32'd0);
`endif

        // Junk before sync is ignored; empty image loads immediately.
        snap = done0_cnt;
        send_byte(0, 8'h00);
        send_byte(0, 8'h7F);
        send_frame(0, 0, 4096, 1'b0, 1'b0);
        expect_end("empty", 0, 1, 1'b1, 3'b000);

        // Timeout after a partial word.
        snap = done0_cnt;
        send_byte(0, 8'hA5); send_byte(0, 8'h01); send_byte(0, 8'h00);
        send_byte(0, 8'h11); send_byte(0, 8'h22);
        check("tmo_busy_mid", {30'd0, busy0, crst0}, 32'd2);
        cyc = 0;
        while (!err0[2] && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("tmo_window", {31'd0, (cyc >= 600 && cyc <= 680)}, 32'd1);
        expect_end("tmo", 0, 0, 1'b0, 3'b100);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Reset during DATA: outputs go to reset values without a clock edge.
        send_byte(0, 8'hA5); send_byte(0, 8'h02); send_byte(0, 8'h00);
        send_byte(0, 8'h11); send_byte(0, 8'h22);
        check("mid_busy", {31'd0, busy0}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_after", {30'd0, busy0, crst0}, 32'd1);

        // Overflow on a 2-word memory: 3 words sent, only 2 written.
        fw[0] = 32'h0000_0001; fw[1] = 32'h0000_0002; fw[2] = 32'h0000_0003;
        check("model_csum_ovf", {24'd0, frame_sum(3)}, 32'h0000_0009);
        snap = done1_cnt;
        send_frame(1, 3, 2, 1'b0, 1'b0);
        expect_end("ovf", 1, 1, 1'b1, 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
